// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage types and defaults
package core_pkg;

    localparam int unsigned XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int unsigned INC_WORD         = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch request handshake between PC generator and IMEM
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus_inc_o;
    logic            fetch_valid_o;
    logic            fetch_ready_i;

    modport master (
        output pc_o,
        output pc_plus_inc_o,
        output fetch_valid_o,
        input  fetch_ready_i
    );

    modport slave (
        input  pc_o,
        input  pc_plus_inc_o,
        input  fetch_valid_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - priority select of the next PC plus misaligned redirect detect
module pc_next_mux #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned INC  = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            accept,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt,
    output logic [XLEN-1:0] pc_next,
    output logic            jump,
    output logic            flush,
    output logic            misaligned,
    output logic            halt_req
);

    localparam logic [XLEN-1:0] LOW_MASK = {{(XLEN-2){1'b0}}, 2'b11};

    always_comb begin
        pc_next    = pc;
        jump       = 1'b0;
        flush      = 1'b0;
        misaligned = 1'b0;
        halt_req   = 1'b0;
        if (trap_valid) begin
            // trap targets are forced aligned, never reported as misaligned
            pc_next = trap_target & ~LOW_MASK;
            jump    = 1'b1;
            flush   = 1'b1;
        end else if (redirect_valid) begin
            flush = 1'b1;
            if (redirect_target[1:0] == 2'b00) begin
                pc_next = redirect_target;
                jump    = 1'b1;
            end else begin
                misaligned = 1'b1;
            end
        end else begin
            if (accept) begin
                pc_next = pc + XLEN'(INC);
            end
            halt_req = halt;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with redirect, trap, stall and halt
module pc_gen
    import core_pkg::*;
#(
    parameter int unsigned      XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int unsigned      INC          = INC_WORD
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_gen_if.master        fetch,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            halt_i,
    output logic            flush_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] misaligned_addr_o
);

    pc_state_e       state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic            valid_q, valid_n;
    logic            flush_n, mis_n;
    logic [XLEN-1:0] mis_addr_q, mis_addr_n;

    logic            accept;
    logic [XLEN-1:0] mux_pc;
    logic            mux_jump, mux_flush, mux_mis, mux_halt;

    assign accept = valid_q && fetch.fetch_ready_i && !stall_i;

    pc_next_mux #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_next_mux (
        .pc              (pc_q),
        .accept          (accept),
        .trap_valid      (trap_valid_i),
        .trap_target     (trap_target_i),
        .redirect_valid  (redirect_valid_i),
        .redirect_target (redirect_target_i),
        .halt            (halt_i),
        .pc_next         (mux_pc),
        .jump            (mux_jump),
        .flush           (mux_flush),
        .misaligned      (mux_mis),
        .halt_req        (mux_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            flush_o    <= 1'b0;
            misaligned_o <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            valid_q    <= valid_n;
            flush_o    <= flush_n;
            misaligned_o <= mis_n;
            mis_addr_q <= mis_addr_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        flush_n    = 1'b0;
        mis_n      = 1'b0;
        mis_addr_n = mis_addr_q;
        case (state_q)
            BOOT: begin
                // redirects and traps arriving before the first fetch are dropped
                state_n = RUN;
            end
            RUN: begin
                pc_n    = mux_pc;
                flush_n = mux_flush;
                mis_n   = mux_mis;
                if (mux_mis) mis_addr_n = redirect_target_i;
                if (mux_halt) state_n = HALT;
            end
            HALT: begin
                // valid is low here, so the mux only moves pc on a redirect/trap
                pc_n    = mux_pc;
                flush_n = mux_flush;
                mis_n   = mux_mis;
                if (mux_mis) mis_addr_n = redirect_target_i;
                if (mux_jump) state_n = RUN;
            end
            default: begin
                state_n = BOOT;
                pc_n    = RESET_VECTOR;
            end
        endcase
        valid_n = (state_n == RUN);
    end

    assign fetch.pc_o          = pc_q;
    assign fetch.pc_plus_inc_o = pc_q + XLEN'(INC);
    assign fetch.fetch_valid_o = valid_q;
    assign misaligned_addr_o   = mis_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed table-driven bench for pc_gen
module tb_pc_gen;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        trap_valid_i;
    logic [31:0] trap_target_i;
    logic        halt_i;
    logic        flush_o;
    logic        misaligned_o;
    logic [31:0] misaligned_addr_o;

    pc_gen_if #(.XLEN(32)) fif ();

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .INC          (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch             (fif),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .trap_valid_i      (trap_valid_i),
        .trap_target_i     (trap_target_i),
        .halt_i            (halt_i),
        .flush_o           (flush_o),
        .misaligned_o      (misaligned_o),
        .misaligned_addr_o (misaligned_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        ready;
        logic        rv;
        logic [31:0] rt;
        logic        tv;
        logic [31:0] tt;
        logic        halt;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_flush;
        logic        e_mis;
        logic [31:0] e_addr;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [0:NVEC-1];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic ready, input logic rv, input logic [31:0] rt,
                         input logic tv, input logic [31:0] tt, input logic halt);
        stall_i           = stall;
        fif.fetch_ready_i = ready;
        redirect_valid_i  = rv;
        redirect_target_i = rt;
        trap_valid_i      = tv;
        trap_target_i     = tt;
        halt_i            = halt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic valid,
                           input logic flush, input logic mis, input logic [31:0] addr);
        chk({tag, " pc"},       fif.pc_o, pc);
        chk({tag, " pc_plus"},  fif.pc_plus_inc_o, pc + 32'd4);
        chk({tag, " valid"},    {31'd0, fif.fetch_valid_o}, {31'd0, valid});
        chk({tag, " flush"},    {31'd0, flush_o}, {31'd0, flush});
        chk({tag, " mis"},      {31'd0, misaligned_o}, {31'd0, mis});
        chk({tag, " mis_addr"}, misaligned_addr_o, addr);
    endtask

    initial begin
        //            stall ready rv  rt             tv  tt            halt | pc            v  f  m  addr
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h4,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h8,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'hC,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0,   1'b0, 32'h40,       1'b1, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h40,       1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h40,       1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h44,       1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h44,       1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h42,       1'b0, 32'h0,   1'b0, 32'h44,       1'b1, 1'b1, 1'b1, 32'h42};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 32'h100,      1'b1, 1'b1, 1'b0, 32'h42};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h104,      1'b1, 1'b0, 1'b0, 32'h42};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h80,       1'b1, 32'h200, 1'b0, 32'h200,      1'b1, 1'b1, 1'b0, 32'h42};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h203, 1'b0, 32'h200,      1'b1, 1'b1, 1'b0, 32'h42};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,   1'b0, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 32'h42};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h42};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h4,        1'b0, 1'b0, 1'b0, 32'h42};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #3;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        chk_all("boot", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].ready, vecs[i].rv, vecs[i].rt, vecs[i].tv, vecs[i].tt, vecs[i].halt);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_flush, vecs[i].e_mis, vecs[i].e_addr);
        end

        // halted: frozen for ten cycles even with ready high
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt pc", fif.pc_o, 32'h4);
            chk("halt valid", {31'd0, fif.fetch_valid_o}, 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
        step();
        chk("halt trap pc", fif.pc_o, 32'h300);
        chk("halt trap valid", {31'd0, fif.fetch_valid_o}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        chk("resume pc", fif.pc_o, 32'h304);

        // halt while stalled: no accept, pc holds
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step();
        chk("halt stall pc", fif.pc_o, 32'h304);
        chk("halt stall valid", {31'd0, fif.fetch_valid_o}, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
        step();
        chk("halt redir pc", fif.pc_o, 32'h500);
        chk("halt redir valid", {31'd0, fif.fetch_valid_o}, 32'd1);

        // misaligned pulse cancelled by an asynchronous reset
        drive(1'b0, 1'b1, 1'b1, 32'h602, 1'b0, 32'h0, 1'b0);
        step();
        chk_all("mis602", 32'h500, 1'b1, 1'b1, 1'b1, 32'h602);
        drive(1'b0, 1'b1, 1'b1, 32'h60C, 1'b0, 32'h0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_all("rst held", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        step();
        chk_all("boot redir ignored", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        chk_all("post rst run", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
